// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// The pipeline side is the master: it issues operations, takes results and can flush.
interface riscv_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, func3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, func3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Works on operand magnitudes: shift-add for multiply, restoring division for divide,
// UNROLL steps per CALC cycle, then a single FIXUP cycle restores signs and picks the
// output half. Divide-by-zero and signed overflow are resolved at accept time.
module riscv_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  riscv_muldiv_unit_if.slave bus
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [2:0]      func3_reg;
  logic            neg_res_reg;   // product / quotient must be negated
  logic            neg_rem_reg;   // remainder takes the dividend's sign
  logic [XLEN-1:0] hi_reg;        // mul: upper partial product; div: partial remainder
  logic [XLEN-1:0] lo_reg;        // mul: multiplier -> low product; div: dividend -> quotient
  logic [XLEN-1:0] opnd_reg;      // mul: |multiplicand|; div: |divisor|
  logic [XLEN-1:0] result_reg;
  logic            out_valid_reg;

  logic            is_div_in;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] special_res;

  // Decode the incoming request: signedness, magnitudes and the early-out cases
  always_comb begin
    is_div_in = bus.func3[2];
    // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed
    a_signed  = is_div_in ? ~bus.func3[0] : (bus.func3[1:0] != 2'b11);
    b_signed  = is_div_in ? ~bus.func3[0] : ~bus.func3[1];
    a_neg     = a_signed & bus.op_a[XLEN-1];
    b_neg     = b_signed & bus.op_b[XLEN-1];
    a_abs     = a_neg ? -bus.op_a : bus.op_a;
    b_abs     = b_neg ? -bus.op_b : bus.op_b;
    b_zero    = (bus.op_b == '0);
    sgn_ovf   = ~bus.func3[0] & (bus.op_a == MIN_INT) & (bus.op_b == '1);
    special   = is_div_in & (b_zero | sgn_ovf);
    if (b_zero) begin
      special_res = bus.func3[1] ? bus.op_a : '1;
    end else begin
      special_res = bus.func3[1] ? '0 : bus.op_a;
    end
  end

  // Unrolled datapath: one stage per bit resolved in a CALC cycle
  logic [UNROLL:0][XLEN-1:0] hi_stage;
  logic [UNROLL:0][XLEN-1:0] lo_stage;

  assign hi_stage[0] = hi_reg;
  assign lo_stage[0] = lo_reg;

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [XLEN:0] mul_sum;
      logic [XLEN:0] div_rem;
      logic [XLEN:0] div_diff;

      // Both step kinds are formed; the latched opcode picks one
      always_comb begin
        mul_sum  = {1'b0, hi_stage[gi]} + (lo_stage[gi][0] ? {1'b0, opnd_reg} : '0);
        div_rem  = {hi_stage[gi], lo_stage[gi][XLEN-1]};
        div_diff = div_rem - {1'b0, opnd_reg};
      end

      // A set top bit of div_diff is a borrow: keep the old remainder, quotient bit 0
      assign hi_stage[gi+1] = func3_reg[2]
                              ? (div_diff[XLEN] ? div_rem[XLEN-1:0] : div_diff[XLEN-1:0])
                              : mul_sum[XLEN:1];
      assign lo_stage[gi+1] = func3_reg[2]
                              ? {lo_stage[gi][XLEN-2:0], ~div_diff[XLEN]}
                              : {mul_sum[0], lo_stage[gi][XLEN-1:1]};
    end
  endgenerate

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  // Sign restoration and output-half selection used in FIXUP
  always_comb begin
    prod     = {hi_reg, lo_reg};
    prod_fix = neg_res_reg ? -prod : prod;
    quo_fix  = neg_res_reg ? -lo_reg : lo_reg;
    rem_fix  = neg_rem_reg ? -hi_reg : hi_reg;
    if (func3_reg[2]) begin
      fix_res = func3_reg[1] ? rem_fix : quo_fix;
    end else if (func3_reg[1:0] == 2'b00) begin
      fix_res = prod_fix[XLEN-1:0];
    end else begin
      fix_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Control FSM and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      func3_reg     <= '0;
      neg_res_reg   <= 1'b0;
      neg_rem_reg   <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      opnd_reg      <= '0;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over any handshake this cycle; the last result value is left alone
      state_reg     <= IDLE;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            func3_reg   <= bus.func3;
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            hi_reg      <= '0;
            lo_reg      <= is_div_in ? a_abs : b_abs;
            opnd_reg    <= is_div_in ? b_abs : a_abs;
            if (special) begin
              result_reg    <= special_res;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              count_reg <= CW'(STEPS);
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          hi_reg    <= hi_stage[UNROLL];
          lo_reg    <= lo_stage[UNROLL];
          count_reg <= count_reg - 1'b1;
          if (count_reg == CW'(1)) begin
            state_reg <= FIXUP;
          end
        end
        FIXUP: begin
          result_reg    <= fix_res;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: a 32-bit/1-bit-per-cycle instance and a
// 64-bit/4-bits-per-cycle instance sharing clock and reset.
module tb_riscv_muldiv_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  riscv_muldiv_unit_if #(.XLEN(32)) b32 ();
  riscv_muldiv_unit_if #(.XLEN(64)) b64 ();

  riscv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  riscv_muldiv_unit #(.XLEN(64), .UNROLL(4)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op on the 32-bit unit; lat counts edges from accept until out_valid (-1 on timeout)
  task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, output logic [31:0] res, output int lat);
    @(negedge clk);
    b32.in_valid = 1'b1; b32.func3 = f; b32.op_a = a; b32.op_b = b; b32.out_ready = ~hold;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 200; c++) begin
      if (b32.out_valid) begin
        lat = c;
        res = b32.result;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0 && !hold) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    b64.in_valid = 1'b1; b64.func3 = f; b64.op_a = a; b64.op_b = b; b64.out_ready = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 200; c++) begin
      if (b64.out_valid) begin
        lat = c;
        res = b64.result;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (b32.in_ready !== 1'b1 || b32.busy !== 1'b0 || b32.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset32_ctl: got rdy=%b busy=%b ov=%b want 1 0 0", b32.in_ready, b32.busy, b32.out_valid);
    end
    total++;
    if (b32.result !== 32'h0) begin
      bad++;
      $display("FAIL reset32_result: got %h want 0", b32.result);
    end
    total++;
    if (b64.in_ready !== 1'b1 || b64.busy !== 1'b0 || b64.out_valid !== 1'b0 || b64.result !== 64'h0) begin
      bad++;
      $display("FAIL reset64: got rdy=%b busy=%b ov=%b res=%h", b64.in_ready, b64.busy, b64.out_valid, b64.result);
    end
    $display("reset checked");
  endtask

  task automatic test_mul();
    logic [2:0]  fv [7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3};
    logic [31:0] av [7] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd0, 32'h80000000};
    logic [31:0] bv [7] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd5, 32'd2};
    logic [31:0] ev [7] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run32(fv[i], av[i], bv[i], 1'b0, res, lat);
      total++;
      if (res !== ev[i] || lat !== 34) begin
        bad++;
        $display("FAIL mul%0d: got %h lat %0d want %h lat 34", i, res, lat, ev[i]);
      end
      $display("mul f=%0d a=%h b=%h -> %h lat %0d", fv[i], av[i], bv[i], res, lat);
    end
  endtask

  task automatic test_div();
    logic [2:0]  fv [7] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5};
    logic [31:0] av [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFF};
    logic [31:0] bv [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
    logic [31:0] ev [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run32(fv[i], av[i], bv[i], 1'b0, res, lat);
      total++;
      if (res !== ev[i] || lat !== 34) begin
        bad++;
        $display("FAIL div%0d: got %h lat %0d want %h lat 34", i, res, lat, ev[i]);
      end
      $display("div f=%0d a=%h b=%h -> %h lat %0d", fv[i], av[i], bv[i], res, lat);
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] av [6] = '{32'h1234, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'd9};
    logic [31:0] bv [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] ev [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd9};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run32(fv[i], av[i], bv[i], 1'b0, res, lat);
      total++;
      if (res !== ev[i] || lat !== 1) begin
        bad++;
        $display("FAIL special%0d: got %h lat %0d want %h lat 1", i, res, lat, ev[i]);
      end
      $display("special f=%0d a=%h b=%h -> %h lat %0d", fv[i], av[i], bv[i], res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    run32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, lat);
    total++;
    if (res !== 32'hFFFFFFFE || lat !== 34) begin
      bad++;
      $display("FAIL b2b_first: got %h lat %0d want fffffffe lat 34", res, lat);
    end
    run32(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, res, lat);
    total++;
    if (res !== 32'hFFFFFFFD || lat !== 34) begin
      bad++;
      $display("FAIL b2b_second: got %h lat %0d want fffffffd lat 34", res, lat);
    end
    $display("back-to-back second -> %h lat %0d", res, lat);
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    run32(3'd0, 32'd6, 32'd7, 1'b1, res, lat);
    total++;
    if (res !== 32'd42 || lat !== 34) begin
      bad++;
      $display("FAIL bp_result: got %h lat %0d want 0000002a lat 34", res, lat);
    end
    // offer a divide-by-zero that would complete instantly if wrongly accepted
    @(negedge clk);
    b32.in_valid = 1'b1; b32.func3 = 3'd5; b32.op_a = 32'd9; b32.op_b = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (b32.out_valid !== 1'b1 || b32.result !== 32'd42 || b32.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b res=%h rdy=%b want 1 0000002a 0", c, b32.out_valid, b32.result, b32.in_ready);
      end
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got ov=%b rdy=%b want 0 1", b32.out_valid, b32.in_ready);
    end
    run32(3'd5, 32'd100, 32'd7, 1'b0, res, lat);
    total++;
    if (res !== 32'd14 || lat !== 34) begin
      bad++;
      $display("FAIL bp_next: got %h lat %0d want 0000000e lat 34", res, lat);
    end
    $display("backpressure release, next op -> %h lat %0d", res, lat);
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    bit seen;
    @(negedge clk);
    b32.in_valid = 1'b1; b32.func3 = 3'd0; b32.op_a = 32'd7; b32.op_b = 32'hFFFFFFFD; b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0;
    total++;
    if (b32.busy !== 1'b0 || b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_calc: got busy=%b ov=%b rdy=%b want 0 0 1", b32.busy, b32.out_valid, b32.in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL flush_noresult: got out_valid seen=%b want 0", seen);
    end
    run32(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, res, lat);
    total++;
    if (res !== 32'hFFFFFFFD || lat !== 34) begin
      bad++;
      $display("FAIL flush_after: got %h lat %0d want fffffffd lat 34", res, lat);
    end
    // flush with a request in the same cycle: the request is dropped
    @(negedge clk);
    b32.in_valid = 1'b1; b32.func3 = 3'd5; b32.op_a = 32'd1; b32.op_b = 32'd0; b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    b32.flush = 1'b0;
    total++;
    if (b32.out_valid !== 1'b0 || b32.busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_accept: got ov=%b busy=%b want 0 0", b32.out_valid, b32.busy);
    end
    // flush while holding a finished result
    run32(3'd7, 32'd100, 32'd7, 1'b1, res, lat);
    total++;
    if (res !== 32'd2 || lat !== 34) begin
      bad++;
      $display("FAIL flush_done_pre: got %h lat %0d want 00000002 lat 34", res, lat);
    end
    @(negedge clk);
    b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0;
    b32.out_ready = 1'b1;
    total++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_done: got ov=%b rdy=%b want 0 1", b32.out_valid, b32.in_ready);
    end
    $display("flush scenarios done");
  endtask

  task automatic test_rst_mid();
    logic [31:0] res;
    int lat;
    @(negedge clk);
    b32.in_valid = 1'b1; b32.func3 = 3'd0; b32.op_a = 32'd3; b32.op_b = 32'd5; b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (b32.busy !== 1'b0 || b32.out_valid !== 1'b0 || b32.result !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid: got busy=%b ov=%b res=%h want 0 0 0", b32.busy, b32.out_valid, b32.result);
    end
    run32(3'd0, 32'd3, 32'd5, 1'b0, res, lat);
    total++;
    if (res !== 32'd15 || lat !== 34) begin
      bad++;
      $display("FAIL rst_after: got %h lat %0d want 0000000f lat 34", res, lat);
    end
    $display("rst mid-op, next op -> %h lat %0d", res, lat);
  endtask

  task automatic test_xlen64();
    logic [2:0]  fv [10] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd7, 3'd4};
    logic [63:0] av [10] = '{64'd7, '1, 64'h8000000000000000, '1, 64'hFFFFFFFFFFFFFFF9,
                             64'hFFFFFFFFFFFFFFF9, 64'h100000000, 64'h100000000, 64'h123456789,
                             64'h8000000000000000};
    logic [63:0] bv [10] = '{64'hFFFFFFFFFFFFFFFD, '1, 64'h8000000000000000, 64'd2, 64'd2,
                             64'd2, 64'd3, 64'd3, 64'd16, '1};
    logic [63:0] ev [10] = '{64'hFFFFFFFFFFFFFFEB, 64'hFFFFFFFFFFFFFFFE, 64'h4000000000000000, '1,
                             64'hFFFFFFFFFFFFFFFD, '1, 64'h55555555, 64'd1, 64'd9,
                             64'h8000000000000000};
    int          lv [10] = '{18, 18, 18, 18, 18, 18, 18, 18, 18, 1};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run64(fv[i], av[i], bv[i], res, lat);
      total++;
      if (res !== ev[i] || lat !== lv[i]) begin
        bad++;
        $display("FAIL x64_%0d: got %h lat %0d want %h lat %0d", i, res, lat, ev[i], lv[i]);
      end
      $display("x64 f=%0d a=%h b=%h -> %h lat %0d", fv[i], av[i], bv[i], res, lat);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.func3 = '0; b32.op_a = '0; b32.op_b = '0; b32.out_ready = 1'b1;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.func3 = '0; b64.op_a = '0; b64.op_b = '0; b64.out_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_xlen64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
